if_fetch: RTL

Instruction-fetch front end for the RV32IC core. It is the requesting side of the instruction memory interface. It drives word addresses to the synchronous-read instruction memory and absorbs that memory's one-cycle read latency. It splits the returned 32-bit words into 16-bit parcels and presents one aligned instruction per handshake to decode, either 32-bit or 16-bit compressed. It also handles 32-bit instructions that straddle a word boundary, and control-flow redirects from execute.

---
 rtl/if_pkg.sv | 16 +
 rtl/fetch_parcel_queue.sv | 63 ++++++
 rtl/if_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package if_pkg;

  localparam int unsigned PARCEL_W = 16;
  localparam int unsigned QDEPTH   = 4;

  localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

  typedef logic [PARCEL_W-1:0] parcel_t;

  // A parcel whose low opcode bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_compressed(parcel_t p);
    return p[1:0] != OPC_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/fetch_parcel_queue.sv
// 4-entry 16-bit parcel shift queue; head at index 0.
// Ports: clk, reset (sync, active-high), flush (empties the queue),
//   pop_n (0..2 parcels removed from the head), push_n (0..2 parcels appended),
//   push_first/push_second (appended in that order), head0/head1 (first two
//   entries), count (occupancy 0..4).
module fetch_parcel_queue
  import if_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [1:0] pop_n,
  input  logic [1:0] push_n,
  input  parcel_t    push_first,
  input  parcel_t    push_second,
  output parcel_t    head0,
  output parcel_t    head1,
  output logic [2:0] count
);

  parcel_t    q     [QDEPTH];
  parcel_t    q_nxt [QDEPTH];
  logic [2:0] base;
  logic [2:0] count_nxt;

  // Shift out popped parcels, then append pushes behind the survivors.
  always_comb begin
    base      = count - 3'(pop_n);
    count_nxt = base + 3'(push_n);
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      q_nxt[2'(i)] = '0;
      if (i + 32'(pop_n) < QDEPTH) begin
        q_nxt[2'(i)] = q[2'(i + 32'(pop_n))];
      end
    end
    if (push_n != 2'd0 && base < 3'(QDEPTH)) begin
      q_nxt[base[1:0]] = push_first;
    end
    if (push_n == 2'd2 && base < 3'(QDEPTH - 1)) begin
      q_nxt[2'(base + 3'd1)] = push_second;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q[2'(i)] <= '0;
      end
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count_nxt;
      q     <= q_nxt;
    end
  end

  assign head0 = q[0];
  assign head1 = q[1];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) count <= 3'(QDEPTH));

endmodule

// File: rtl/if_fetch.sv
// RV32IC instruction fetch: issues word reads to a 1-cycle synchronous
// instruction memory, splits returned words into parcels and presents one
// aligned 16- or 32-bit instruction per handshake; restarts on redirect.
// Ports: clk, reset (sync, active-high), imem_addr/imem_dout (memory side),
//   redirect_valid/redirect_pc (restart from execute), id_ready (decode
//   accepts), if_valid/if_instr/if_pc/if_compressed (instruction to decode).
module if_fetch
  import if_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [31:0]           if_instr,
  output logic [31:0]           if_pc,
  output logic                  if_compressed
);

  logic [ADDR_WIDTH-1:0] fetch_waddr;
  logic [ADDR_WIDTH-1:0] redirect_waddr;
  logic                  rsp_pending;
  logic                  drop_low;
  parcel_t               head0;
  parcel_t               head1;
  logic [2:0]            count;
  logic                  head_comp;
  logic                  fire;
  logic                  issue;
  logic [1:0]            pop_n;
  logic [1:0]            push_n;
  logic [2:0]            count_nxt;
  parcel_t               push_first;

  assign redirect_waddr = redirect_pc[ADDR_WIDTH+1:2];

  // Decode-side view depends only on queue registers; push/pop/issue control.
  always_comb begin
    head_comp     = is_compressed(head0);
    if_valid      = head_comp ? (count != 3'd0) : (count >= 3'd2);
    if_compressed = if_valid & head_comp;
    if_instr      = '0;
    if (if_valid) begin
      if_instr = head_comp ? {16'h0000, head0} : {head1, head0};
    end
    fire       = if_valid & id_ready & ~redirect_valid;
    pop_n      = fire ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
    // A response in flight during a redirect belongs to the old stream.
    push_n     = (rsp_pending & ~redirect_valid) ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
    push_first = drop_low ? imem_dout[2*PARCEL_W-1:PARCEL_W] : imem_dout[PARCEL_W-1:0];
    count_nxt  = count + 3'(push_n) - 3'(pop_n);
    // At most one word in flight, so issuing at <=2 keeps the queue within 4.
    issue      = count_nxt <= 3'd2;
    imem_addr  = redirect_valid ? redirect_waddr : fetch_waddr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pending <= 1'b0;
      fetch_waddr <= RESET_PC[ADDR_WIDTH+1:2];
      drop_low    <= RESET_PC[1];
      if_pc       <= RESET_PC;
    end else if (redirect_valid) begin
      if_pc       <= redirect_pc & ~32'd1;
      drop_low    <= redirect_pc[1];
      fetch_waddr <= redirect_waddr + ADDR_WIDTH'(1);
      rsp_pending <= 1'b1;
    end else begin
      if (fire) begin
        if_pc <= if_pc + (head_comp ? 32'd2 : 32'd4);
      end
      if (rsp_pending) begin
        drop_low <= 1'b0;
      end
      if (issue) begin
        rsp_pending <= 1'b1;
        fetch_waddr <= fetch_waddr + ADDR_WIDTH'(1);
      end else begin
        rsp_pending <= 1'b0;
      end
    end
  end

  fetch_parcel_queue u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (redirect_valid),
    .pop_n       (pop_n),
    .push_n      (push_n),
    .push_first  (push_first),
    .push_second (imem_dout[2*PARCEL_W-1:PARCEL_W]),
    .head0       (head0),
    .head1       (head1),
    .count       (count)
  );

endmodule
